flop_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one single-bit state register (flop_q) among NUM_REQ requesters.
- Each requester acquires exclusive ownership through a req/grant/done handshake, writes the register while it is owner, then releases.
- Sits between the requesting control blocks and the shared flop resource; no other block writes flop_q.

---
 rtl/flop_arbiter_if.sv | 43 ++++
 rtl/flop_arbiter.sv | 152 +++++++++++++++
 tb/tb_flop_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/flop_arbiter_if.sv
// -----------------------------------------------------------------------------
// flop_arbiter_if
// Bundles the requester-side handshake and the shared flop outputs of
// flop_arbiter so that requesters and the arbiter connect through one port.
//
// Handshake (all signals sampled on the rising clock edge):
//   - A requester holds req[i] high (level) for as long as it wants ownership.
//   - The arbiter answers with a registered one-hot grant; grant_valid is the
//     OR of grant and grant_idx names the owner (0 when nobody owns).
//   - While granted, the owner may write the shared bit with wr_en/wr_data.
//   - The owner releases by pulsing done[i] or dropping req[i]; the arbiter
//     may also force a release after HOLD_MAX cycles and flags it on timeout.
//   - done/wr_en/wr_data from anyone but the current owner are ignored.
//
// Modports:
//   master : requester side (drives req/done/wr_en/wr_data)
//   slave  : arbiter side   (drives grant/grant_valid/grant_idx/flop_q/timeout)
// -----------------------------------------------------------------------------
interface flop_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] done;
    logic [NUM_REQ-1:0] wr_en;
    logic [NUM_REQ-1:0] wr_data;
    logic [NUM_REQ-1:0] grant;
    logic               grant_valid;
    logic [IDX_W-1:0]   grant_idx;
    logic               flop_q;
    logic               timeout;

    modport master (
        output req, done, wr_en, wr_data,
        input  grant, grant_valid, grant_idx, flop_q, timeout
    );

    modport slave (
        input  req, done, wr_en, wr_data,
        output grant, grant_valid, grant_idx, flop_q, timeout
    );
endinterface

// File: rtl/flop_arbiter.sv
// -----------------------------------------------------------------------------
// flop_arbiter
// Round-robin arbiter that hands exclusive write ownership of one shared
// single-bit register among NUM_REQ requesters. Each grant lasts until the
// owner releases it or HOLD_MAX cycles elapse, followed by a one-cycle GAP
// and an IDLE arbitration cycle.
//
// Ports:
//   flip      : clock, all state updates on posedge
//   reset     : asynchronous active-low reset
//   bus       : flop_arbiter_if.slave (req/done/wr_en/wr_data in,
//               grant/grant_valid/grant_idx/flop_q/timeout out)
//   state_dbg : current FSM state (0=IDLE, 1=OWN, 2=GAP) for observation
// -----------------------------------------------------------------------------
module flop_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int HOLD_MAX = 8
) (
    input  logic                flip,
    input  logic                reset,
    flop_arbiter_if.slave       bus,
    output logic [1:0]          state_dbg
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int HC_W  = $clog2(HOLD_MAX) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               grant_valid_q, grant_valid_d;
    logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [HC_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic               flop_q, flop_d;
    logic               timeout_q, timeout_d;

    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W:0]     cand;
    logic               rel_normal;
    logic               rel_force;
    logic [IDX_W-1:0]   next_ptr;

    // Round-robin search: first requester at or after rr_ptr, wrapping.
    // cand is one bit wider so rr_ptr + offset cannot overflow before the wrap.
    always_comb begin : rr_pick
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!pick_found && bus.req[cand[IDX_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // Owner-driven release beats the hold timer when both happen together.
    assign rel_normal = bus.done[grant_idx_q] || !bus.req[grant_idx_q];
    assign rel_force  = !rel_normal && (hold_cnt_q == HC_W'(HOLD_MAX - 1));
    assign next_ptr   = (grant_idx_q == IDX_W'(NUM_REQ - 1)) ? '0
                                                              : grant_idx_q + IDX_W'(1);

    // State and datapath registers.
    always_ff @(posedge flip or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_idx_q   <= '0;
            rr_ptr_q      <= '0;
            hold_cnt_q    <= '0;
            flop_q        <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            grant_idx_q   <= grant_idx_d;
            rr_ptr_q      <= rr_ptr_d;
            hold_cnt_q    <= hold_cnt_d;
            flop_q        <= flop_d;
            timeout_q     <= timeout_d;
        end
    end

    // Next-state logic.
    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (pick_found) state_d = ST_OWN;
            ST_OWN:  if (rel_normal || rel_force) state_d = ST_GAP;
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next values.
    always_comb begin : output_next
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        rr_ptr_d    = rr_ptr_q;
        hold_cnt_d  = hold_cnt_q;
        flop_d      = flop_q;
        timeout_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_d     = NUM_REQ'(1) << pick_idx;
                    grant_idx_d = pick_idx;
                    hold_cnt_d  = '0;
                end
            end
            ST_OWN: begin
                // A write on the releasing edge still lands.
                if (bus.wr_en[grant_idx_q]) begin
                    flop_d = bus.wr_data[grant_idx_q];
                end
                if (rel_normal || rel_force) begin
                    grant_d     = '0;
                    grant_idx_d = '0;
                    hold_cnt_d  = '0;
                    rr_ptr_d    = next_ptr;
                    timeout_d   = rel_force;
                end else begin
                    hold_cnt_d = hold_cnt_q + HC_W'(1);
                end
            end
            default: begin
                grant_d     = '0;
                grant_idx_d = '0;
            end
        endcase
        grant_valid_d = |grant_d;
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.grant_idx   = grant_idx_q;
    assign bus.flop_q      = flop_q;
    assign bus.timeout     = timeout_q;
    assign state_dbg       = state_q;
endmodule

// File: tb/tb_flop_arbiter.sv
module tb_flop_arbiter;
  logic flip;
  logic reset;
  logic [1:0] state_dbg;

  flop_arbiter_if #(.NUM_REQ(4)) bif ();

  flop_arbiter #(.NUM_REQ(4), .HOLD_MAX(8)) dut (
    .flip      (flip),
    .reset     (reset),
    .bus       (bif.slave),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial flip = 1'b0;
  always #5 flip = ~flip;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge flip);
    #1;
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] d,
                       input logic [3:0] we, input logic [3:0] wd);
    bif.req = r;
    bif.done = d;
    bif.wr_en = we;
    bif.wr_data = wd;
  endtask

  // scoreboard monitor: every new grant pops one expected owner index
  initial begin : monitor
    logic prev_gv;
    logic [1:0] e;
    logic [3:0] oh;
    prev_gv = 1'b0;
    forever begin
      @(negedge flip);
      if (bif.grant_valid && !prev_gv) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_grant: got idx %0d expected none", bif.grant_idx);
        end else begin
          e = exp_q.pop_front();
          oh = 4'b0001 << e;
          chk("sb_grant_idx", bif.grant_idx, e);
          chk("sb_grant_onehot", bif.grant, oh);
        end
      end
      prev_gv = bif.grant_valid;
    end
  end

  initial begin : stimulus
    reset = 1'b0;
    drive(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    #3;
    chk("rst_grant", bif.grant, 4'b0000);
    chk("rst_grant_valid", bif.grant_valid, 1'b0);
    chk("rst_grant_idx", bif.grant_idx, 2'd0);
    chk("rst_flop_q", bif.flop_q, 1'b0);
    chk("rst_timeout", bif.timeout, 1'b0);
    chk("rst_state", state_dbg, 2'd0);
    @(negedge flip);
    reset = 1'b1;

    // no requests: stay idle
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_grant_valid", bif.grant_valid, 1'b0);
      chk("idle_timeout", bif.timeout, 1'b0);
      chk("idle_flop_q", bif.flop_q, 1'b0);
      chk("idle_state", state_dbg, 2'd0);
    end

    // req 0110 from rr_ptr 0 -> 1, then done -> 2
    drive(4'b0110, 4'b0000, 4'b0000, 4'b0000);
    exp_q.push_back(2'd1);
    tick();
    chk("s2_grant1", bif.grant, 4'b0010);
    chk("s2_idx1", bif.grant_idx, 2'd1);
    tick();
    bif.done = 4'b0010;
    exp_q.push_back(2'd2);
    tick();
    chk("s2_gap_valid", bif.grant_valid, 1'b0);
    chk("s2_gap_state", state_dbg, 2'd2);
    bif.done = 4'b0000;
    tick();
    chk("s2_idle_valid", bif.grant_valid, 1'b0);
    tick();
    chk("s2_grant2", bif.grant, 4'b0100);
    chk("s2_idx2", bif.grant_idx, 2'd2);
    bif.req = 4'b0000;
    tick();
    chk("s2_reqdrop_release", bif.grant_valid, 1'b0);
    tick();

    // all request, done held: rr_ptr=3 so order 3,0,1,2,3,0
    drive(4'b1111, 4'b1111, 4'b0000, 4'b0000);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd0);
    for (int g = 0; g < 6; g++) begin
      tick();
      chk("rr_own_valid", bif.grant_valid, 1'b1);
      tick();
      chk("rr_gap_valid", bif.grant_valid, 1'b0);
      if (g == 5) drive(4'b0000, 4'b0000, 4'b0000, 4'b0000);
      tick();
      chk("rr_idle_valid", bif.grant_valid, 1'b0);
    end

    // owner 2 never releases: forced release after 8 cycles
    bif.req = 4'b0100;
    exp_q.push_back(2'd2);
    tick();
    chk("to_grant", bif.grant, 4'b0100);
    chk("to_timeout_c0", bif.timeout, 1'b0);
    for (int c = 1; c < 8; c++) begin
      tick();
      chk("to_hold_valid", bif.grant_valid, 1'b1);
      chk("to_hold_timeout", bif.timeout, 1'b0);
    end
    tick();
    chk("to_release_valid", bif.grant_valid, 1'b0);
    chk("to_pulse", bif.timeout, 1'b1);
    bif.req = 4'b0000;
    tick();
    chk("to_pulse_end", bif.timeout, 1'b0);
    // rr_ptr must now be 3: full request picks 3
    drive(4'b1111, 4'b1111, 4'b0000, 4'b0000);
    exp_q.push_back(2'd3);
    tick();
    chk("to_rr_ptr3", bif.grant_idx, 2'd3);
    drive(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick();
    tick();

    // owner 1 writes 1 while non-owner 3 writes 0; release-edge write of 0
    drive(4'b1010, 4'b0000, 4'b1010, 4'b0010);
    exp_q.push_back(2'd1);
    tick();
    chk("wr_no_write_on_grant", bif.flop_q, 1'b0);
    tick();
    chk("wr_owner_write", bif.flop_q, 1'b1);
    tick();
    chk("wr_nonowner_ignored", bif.flop_q, 1'b1);
    bif.wr_data = 4'b0000;
    bif.done = 4'b0010;
    tick();
    chk("wr_release_write", bif.flop_q, 1'b0);
    chk("wr_release_valid", bif.grant_valid, 1'b0);
    drive(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick();

    // reset mid-OWN with flop_q=1 (rr_ptr=2, req 0010 wraps to 1)
    drive(4'b0010, 4'b0000, 4'b0010, 4'b0010);
    exp_q.push_back(2'd1);
    tick();
    tick();
    chk("ar_flop_set", bif.flop_q, 1'b1);
    reset = 1'b0;
    #2;
    chk("ar_grant", bif.grant, 4'b0000);
    chk("ar_grant_valid", bif.grant_valid, 1'b0);
    chk("ar_flop_q", bif.flop_q, 1'b0);
    chk("ar_state", state_dbg, 2'd0);
    drive(4'b1000, 4'b1000, 4'b0000, 4'b0000);
    #1;
    reset = 1'b1;
    exp_q.push_back(2'd3);
    tick();
    chk("ar_regrant_idx", bif.grant_idx, 2'd3);
    tick();
    drive(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick();
    tick();

    chk("sb_queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
